// File: rtl/ss_start_sequencer.sv
// ss_start_sequencer: multi-channel start-request sequencer for one shared
// worker engine. Requests are latched as pending, arbitrated round-robin and
// granted one at a time as a single-cycle o_w_start pulse tagged with a
// channel ID. A job stays busy until i_done or until the watchdog expires.
module ss_start_sequencer #(
   parameter int N_CH        = 4,
   parameter int MODE_EDGE   = 1,
   parameter int TIMEOUT_CYC = 200,
   parameter int TO_W        = 8,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N_CH-1:0] i_start,
   input  logic            i_done,
   output logic            o_w_start,
   output logic [CH_W-1:0] o_ch_id,
   output logic            o_busy,
   output logic [N_CH-1:0] o_pending,
   output logic            o_timeout,
   output logic            o_err_done
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   // Last counter value before an abort; unused when the watchdog is off.
   localparam logic [TO_W-1:0] TO_LAST =
      (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
   // Pointer holds the last winner; starting at N_CH-1 makes ch0 first.
   localparam logic [CH_W-1:0] PTR_RST = CH_W'(N_CH - 1);

   state_t            state;
   logic [N_CH-1:0]   prev;
   logic [N_CH-1:0]   pending;
   logic [N_CH-1:0]   req;
   logic [N_CH-1:0]   grant_oh;
   logic [N_CH-1:0]   grant;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   winner;
   logic [CH_W-1:0]   idx;
   logic              found;
   logic              fire;
   logic [TO_W-1:0]   to_cnt;

   assign o_pending = pending;

   // Request detection: rising edge against the registered history, or raw level.
   always_comb begin
      if (MODE_EDGE != 0) begin
         req = i_start & ~prev;
      end else begin
         req = i_start;
      end
   end

   // Round-robin search over the registered pending set, starting after the last winner.
   always_comb begin
      winner = rr_ptr;
      found  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = CH_W'((int'(rr_ptr) + i) % N_CH);
         if (!found && pending[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // A grant is issued from IDLE, or from WAIT in the cycle the current job completes.
   always_comb begin
      fire     = found && ((state == S_IDLE) || i_done);
      grant_oh = found ? (N_CH'(1) << winner) : '0;
      grant    = fire ? grant_oh : '0;
   end

   // Edge history and pending set; a new request wins over a same-cycle grant clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev    <= '0;
         pending <= '0;
      end else begin
         prev    <= i_start;
         pending <= (pending & ~grant) | req;
      end
   end

   // Control FSM with registered outputs, round-robin pointer and watchdog counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         rr_ptr     <= PTR_RST;
         to_cnt     <= '0;
         o_w_start  <= 1'b0;
         o_ch_id    <= '0;
         o_busy     <= 1'b0;
         o_timeout  <= 1'b0;
         o_err_done <= 1'b0;
      end else begin
         o_w_start  <= 1'b0;
         o_timeout  <= 1'b0;
         o_err_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_done) begin
                  o_err_done <= 1'b1;
               end
               if (fire) begin
                  state     <= S_WAIT;
                  o_w_start <= 1'b1;
                  o_ch_id   <= winner;
                  o_busy    <= 1'b1;
                  rr_ptr    <= winner;
                  to_cnt    <= '0;
               end
            end
            S_WAIT: begin
               if (i_done) begin
                  if (fire) begin
                     o_w_start <= 1'b1;
                     o_ch_id   <= winner;
                     o_busy    <= 1'b1;
                     rr_ptr    <= winner;
                     to_cnt    <= '0;
                  end else begin
                     state  <= S_IDLE;
                     o_busy <= 1'b0;
                  end
               end else if ((TIMEOUT_CYC != 0) && (to_cnt == TO_LAST)) begin
                  state     <= S_IDLE;
                  o_busy    <= 1'b0;
                  o_timeout <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ss_start_sequencer.sv
// Directed bench for ss_start_sequencer: an edge-mode instance driven from a
// per-cycle vector table, plus hand sequences for reset mid-job and a
// level-mode instance.
module tb_ss_start_sequencer;

   typedef struct packed {
      logic       ws;
      logic [1:0] id;
      logic       busy;
      logic [3:0] pend;
      logic       to;
      logic       err;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [3:0] start;
      logic       done;
      outs_t      exp;
   } vec_t;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // edge-mode instance
   logic       e_rst, e_done;
   logic [3:0] e_start;
   logic       e_ws, e_busy, e_to, e_err;
   logic [1:0] e_id;
   logic [3:0] e_pend;
   // level-mode instance
   logic       l_rst, l_done;
   logic [3:0] l_start;
   logic       l_ws, l_busy, l_to, l_err;
   logic [1:0] l_id;
   logic [3:0] l_pend;

   outs_t e_act, l_act;
   assign e_act = {e_ws, e_id, e_busy, e_pend, e_to, e_err};
   assign l_act = {l_ws, l_id, l_busy, l_pend, l_to, l_err};

   ss_start_sequencer #(.N_CH(4), .MODE_EDGE(1), .TIMEOUT_CYC(10), .TO_W(8)) dut_e (
      .i_clk(clk), .i_rst(e_rst), .i_start(e_start), .i_done(e_done),
      .o_w_start(e_ws), .o_ch_id(e_id), .o_busy(e_busy), .o_pending(e_pend),
      .o_timeout(e_to), .o_err_done(e_err)
   );

   ss_start_sequencer #(.N_CH(4), .MODE_EDGE(0), .TIMEOUT_CYC(10), .TO_W(8)) dut_l (
      .i_clk(clk), .i_rst(l_rst), .i_start(l_start), .i_done(l_done),
      .o_w_start(l_ws), .o_ch_id(l_id), .o_busy(l_busy), .o_pending(l_pend),
      .o_timeout(l_to), .o_err_done(l_err)
   );

   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   function automatic outs_t mk(logic ws, logic [1:0] id, logic busy,
                                logic [3:0] pend, logic to, logic err);
      mk = {ws, id, busy, pend, to, err};
   endfunction

   function automatic void add(logic rst, logic [3:0] st, logic dn, outs_t ex);
      vec_t v;
      v.rst   = rst;
      v.start = st;
      v.done  = dn;
      v.exp   = ex;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, outs_t act, outs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got ws=%b id=%0d busy=%b pend=%b to=%b err=%b, want ws=%b id=%0d busy=%b pend=%b to=%b err=%b",
                  name, act.ws, act.id, act.busy, act.pend, act.to, act.err,
                  exp.ws, exp.id, exp.busy, exp.pend, exp.to, exp.err);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Row i: expected outputs in cycle i, then inputs driven for cycle i.
      // 1: edge mode, single held request
      add(0, 4'b0001, 0, mk(0, 0, 0, 4'b0000, 0, 0));  // 0
      add(0, 4'b0001, 0, mk(0, 0, 0, 4'b0001, 0, 0));  // 1 pending after 1 cycle
      add(0, 4'b0001, 0, mk(1, 0, 1, 4'b0000, 0, 0));  // 2 grant ch0
      add(0, 4'b0001, 0, mk(0, 0, 1, 4'b0000, 0, 0));  // 3 no re-fire
      add(0, 4'b0001, 1, mk(0, 0, 1, 4'b0000, 0, 0));  // 4 done
      add(0, 4'b0000, 0, mk(0, 0, 0, 4'b0000, 0, 0));  // 5 busy drops
      add(1, 4'b0000, 0, mk(0, 0, 0, 4'b0000, 0, 0));  // 6 reset
      // 2: round robin over 1011 from reset pointer
      add(0, 4'b1011, 0, mk(0, 0, 0, 4'b0000, 0, 0));  // 7
      add(0, 4'b1011, 0, mk(0, 0, 0, 4'b1011, 0, 0));  // 8
      add(0, 4'b1011, 0, mk(1, 0, 1, 4'b1010, 0, 0));  // 9 ch0
      add(0, 4'b1011, 0, mk(0, 0, 1, 4'b1010, 0, 0));  // 10
      add(0, 4'b1011, 0, mk(0, 0, 1, 4'b1010, 0, 0));  // 11
      add(0, 4'b1011, 1, mk(0, 0, 1, 4'b1010, 0, 0));  // 12 done
      add(0, 4'b1011, 0, mk(1, 1, 1, 4'b1000, 0, 0));  // 13 ch1
      add(0, 4'b1011, 0, mk(0, 1, 1, 4'b1000, 0, 0));  // 14
      add(0, 4'b1011, 0, mk(0, 1, 1, 4'b1000, 0, 0));  // 15
      add(0, 4'b1011, 1, mk(0, 1, 1, 4'b1000, 0, 0));  // 16 done
      add(0, 4'b1011, 0, mk(1, 3, 1, 4'b0000, 0, 0));  // 17 ch3
      add(0, 4'b1011, 0, mk(0, 3, 1, 4'b0000, 0, 0));  // 18
      add(0, 4'b1011, 0, mk(0, 3, 1, 4'b0000, 0, 0));  // 19
      add(0, 4'b0000, 1, mk(0, 3, 1, 4'b0000, 0, 0));  // 20 done, drop
      add(0, 4'b0011, 0, mk(0, 3, 0, 4'b0000, 0, 0));  // 21 ch0+ch1 rise
      add(0, 4'b0011, 0, mk(0, 3, 0, 4'b0011, 0, 0));  // 22
      add(0, 4'b0000, 0, mk(1, 0, 1, 4'b0010, 0, 0));  // 23 ch0 (wraps from ch3)
      // 3: back-to-back, ch2 pending while ch1 pulses with done
      add(0, 4'b0100, 1, mk(0, 0, 1, 4'b0010, 0, 0));  // 24 done, ch2 rises
      add(0, 4'b0100, 1, mk(1, 1, 1, 4'b0100, 0, 0));  // 25 ch1 pulse + done
      add(0, 4'b0000, 0, mk(1, 2, 1, 4'b0000, 0, 0));  // 26 ch2 pulse next cycle
      // 4: watchdog, 10 cycles after ch2 pulse
      for (int k = 27; k <= 35; k++)
         add(0, 4'b0000, 0, mk(0, 2, 1, 4'b0000, 0, 0));
      add(0, 4'b0000, 1, mk(0, 2, 0, 4'b0000, 1, 0));  // 36 timeout, late done
      add(0, 4'b0000, 0, mk(0, 2, 0, 4'b0000, 0, 1));  // 37 err_done
      add(0, 4'b0000, 0, mk(0, 2, 0, 4'b0000, 0, 0));  // 38

      e_rst = 1'b1; e_start = '0; e_done = 1'b0;
      l_rst = 1'b1; l_start = '0; l_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_e", e_act, mk(0, 0, 0, 4'b0000, 0, 0));
      check("reset_l", l_act, mk(0, 0, 0, 4'b0000, 0, 0));
      e_rst = 1'b0;
      l_rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         tick();
         check($sformatf("row%0d", i), e_act, vecs[i].exp);
         e_rst   = vecs[i].rst;
         e_start = vecs[i].start;
         e_done  = vecs[i].done;
      end

      // 6: reset mid-job with pending 0110, release with ch1 still high
      tick(); check("rst_a", e_act, mk(0, 2, 0, 4'b0000, 0, 0));
      e_start = 4'b0001;
      tick(); check("rst_b", e_act, mk(0, 2, 0, 4'b0001, 0, 0));
      e_start = 4'b0111;
      tick(); check("rst_c", e_act, mk(1, 0, 1, 4'b0110, 0, 0));
      e_rst = 1'b1; e_start = 4'b0010;
      tick(); check("rst_d", e_act, mk(0, 0, 0, 4'b0000, 0, 0));
      e_rst = 1'b0;
      tick(); check("rst_e", e_act, mk(0, 0, 0, 4'b0010, 0, 0));
      tick(); check("rst_f", e_act, mk(1, 1, 1, 4'b0000, 0, 0));

      // 5: level mode, held ch3 re-fires on every done
      l_start = 4'b1000;
      tick(); check("lvl_1", l_act, mk(0, 0, 0, 4'b1000, 0, 0));
      tick(); check("lvl_2", l_act, mk(1, 3, 1, 4'b1000, 0, 0));
      tick(); check("lvl_3", l_act, mk(0, 3, 1, 4'b1000, 0, 0));
      l_done = 1'b1;
      tick(); check("lvl_4", l_act, mk(1, 3, 1, 4'b1000, 0, 0));
      l_done = 1'b0; l_start = 4'b0000;
      // the bit latched while held is still served once
      tick(); check("lvl_5", l_act, mk(0, 3, 1, 4'b1000, 0, 0));
      l_done = 1'b1;
      tick(); check("lvl_6", l_act, mk(1, 3, 1, 4'b0000, 0, 0));
      l_done = 1'b0;
      tick(); check("lvl_7", l_act, mk(0, 3, 1, 4'b0000, 0, 0));
      l_done = 1'b1;
      tick(); check("lvl_8", l_act, mk(0, 3, 0, 4'b0000, 0, 0));
      l_done = 1'b0;
      tick(); check("lvl_9", l_act, mk(0, 3, 0, 4'b0000, 0, 0));
      tick(); check("lvl_10", l_act, mk(0, 3, 0, 4'b0000, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
